hci_core_r_outstanding_limiter: RTL and testbench

- Rate-limits outstanding TCDM read transactions on an HCI core port.
- Sits directly upstream of the r_valid filter stage: initiator -> this block -> r_valid filter -> interconnect.
- Counts granted reads against returned r_valid beats, which the filter has already restricted to reads. Withholds new read requests once MAX_OUTSTANDING reads are in flight.
- Exposes occupancy, idle and sticky error status for streamer control FSMs.

---
 rtl/hci_core_r_outstanding_limiter_pkg.sv | 22 ++
 rtl/hci_core_intf.sv | 35 +++
 rtl/hci_core_r_outstanding_limiter.sv | 89 ++++++++
 tb/tb_hci_core_r_outstanding_limiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hci_core_r_outstanding_limiter_pkg.sv
// Shared constants and helpers for the HCI core read outstanding limiter.
// Exports the default read depth and a small decoder that turns the per-cycle
// increment/decrement events into a single counter operation.
package hci_core_r_outstanding_limiter_pkg;

  localparam int unsigned DefaultMaxOutstanding = 4;

  typedef enum logic [1:0] {
    CntHold,
    CntInc,
    CntDec,
    CntUnderflow
  } cnt_op_e;

  // A grant and a returning beat in the same cycle cancel out.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec, input logic empty);
    if (inc && !dec) return CntInc;
    if (dec && !inc) return empty ? CntUnderflow : CntDec;
    return CntHold;
  endfunction

endpackage

// File: rtl/hci_core_intf.sv
// Minimal HCI core port bundle.
// Request side: req/add/wen/data/be/user/lrdy from initiator, gnt from target.
// Response side: r_data/r_valid/r_opc/r_user from target. wen=1 is a read.
interface hci_core_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned UW = 2
) ();

  localparam int unsigned BW = DW / 8;

  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW-1:0] data;
  logic [BW-1:0] be;
  logic [UW-1:0] user;
  logic          lrdy;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_opc;
  logic [UW-1:0] r_user;

  modport initiator (
    output req, add, wen, data, be, user, lrdy,
    input  gnt, r_data, r_valid, r_opc, r_user
  );

  modport target (
    input  req, add, wen, data, be, user, lrdy,
    output gnt, r_data, r_valid, r_opc, r_user
  );

endinterface

// File: rtl/hci_core_r_outstanding_limiter.sv
// Limits the number of in-flight TCDM reads on an HCI core port.
// Ports:
//   clk_i, rst_i (sync, active-high), clear_i (sync soft clear), enable_i
//   tcdm_slave   : upstream initiator side (target modport)
//   tcdm_master  : downstream side toward the r_valid filter (initiator modport)
//   outstanding_o: in-flight read count
//   idle_o       : no reads in flight
//   full_o       : MAX_OUTSTANDING reads in flight
//   err_o        : sticky underflow (r_valid seen with nothing in flight)
module hci_core_r_outstanding_limiter
  import hci_core_r_outstanding_limiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DefaultMaxOutstanding,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  hci_core_intf.target     tcdm_slave,
  hci_core_intf.initiator  tcdm_master,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             idle_o,
  output logic             full_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             block;
  logic             req_fwd;
  logic             inc, dec;

  assign full_o = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign idle_o = (cnt_q == '0);

  // Depends only on registered state: a beat returning this cycle frees its
  // slot for the next cycle, never combinationally into req.
  assign block = enable_i & full_o & tcdm_slave.wen;

  assign req_fwd           = tcdm_slave.req & ~block;
  assign tcdm_master.req   = req_fwd;
  assign tcdm_slave.gnt    = tcdm_master.gnt & ~block;
  assign tcdm_master.add   = tcdm_slave.add;
  assign tcdm_master.wen   = tcdm_slave.wen;
  assign tcdm_master.data  = tcdm_slave.data;
  assign tcdm_master.be    = tcdm_slave.be;
  assign tcdm_master.user  = tcdm_slave.user;
  assign tcdm_master.lrdy  = tcdm_slave.lrdy;

  assign tcdm_slave.r_data  = tcdm_master.r_data;
  assign tcdm_slave.r_valid = tcdm_master.r_valid;
  assign tcdm_slave.r_opc   = tcdm_master.r_opc;
  assign tcdm_slave.r_user  = tcdm_master.r_user;

  assign inc = req_fwd & tcdm_master.gnt & tcdm_slave.wen;
  // The downstream filter already restricts r_valid to read responses.
  assign dec = tcdm_master.r_valid;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (enable_i) begin
      unique case (cnt_op(inc, dec, idle_o))
        CntInc:       cnt_d = cnt_q + CNT_W'(1);
        CntDec:       cnt_d = cnt_q - CNT_W'(1);
        CntUnderflow: err_d = 1'b1;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_hci_core_r_outstanding_limiter.sv
module tb_hci_core_r_outstanding_limiter;

  localparam int unsigned MaxOut = 4;
  localparam int unsigned CntW   = $clog2(MaxOut + 1);

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic enable;
  logic [CntW-1:0] outstanding;
  logic idle, full, err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  hci_core_intf #(.DW(32), .AW(32), .UW(2)) slv_if ();
  hci_core_intf #(.DW(32), .AW(32), .UW(2)) mst_if ();

  hci_core_r_outstanding_limiter #(
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .enable_i     (enable),
    .tcdm_slave   (slv_if),
    .tcdm_master  (mst_if),
    .outstanding_o(outstanding),
    .idle_o       (idle),
    .full_o       (full),
    .err_o        (err)
  );

  // Reference model: in-flight read count and sticky error.
  int m_cnt = 0;
  bit m_err = 1'b0;
  bit m_block, m_inc, m_dec;

  assign m_block = enable && (m_cnt == MaxOut) && slv_if.wen;
  assign m_inc   = enable && slv_if.req && !m_block && mst_if.gnt && slv_if.wen;
  assign m_dec   = enable && mst_if.r_valid;

  always @(posedge clk) begin
    if (rst || clear) begin
      m_cnt <= 0;
      m_err <= 1'b0;
    end else if (m_inc && !m_dec) begin
      m_cnt <= m_cnt + 1;
    end else if (m_dec && !m_inc) begin
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
      else m_err <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_req",   64'(mst_if.req),   64'(slv_if.req && !m_block));
      check("s_gnt",   64'(slv_if.gnt),   64'(mst_if.gnt && !m_block));
      check("m_add",   64'(mst_if.add),   64'(slv_if.add));
      check("m_wen",   64'(mst_if.wen),   64'(slv_if.wen));
      check("m_data",  64'(mst_if.data),  64'(slv_if.data));
      check("m_be",    64'(mst_if.be),    64'(slv_if.be));
      check("m_user",  64'(mst_if.user),  64'(slv_if.user));
      check("m_lrdy",  64'(mst_if.lrdy),  64'(slv_if.lrdy));
      check("s_rdata", 64'(slv_if.r_data), 64'(mst_if.r_data));
      check("s_rvld",  64'(slv_if.r_valid), 64'(mst_if.r_valid));
      check("s_ropc",  64'(slv_if.r_opc), 64'(mst_if.r_opc));
      check("s_ruser", 64'(slv_if.r_user), 64'(mst_if.r_user));
      check("outst",   64'(outstanding),  64'(m_cnt));
      check("idle",    64'(idle),         64'(m_cnt == 0));
      check("full",    64'(full),         64'(m_cnt == MaxOut));
      check("err",     64'(err),          64'(m_err));
    end
  end

  // Apply one cycle of stimulus just after the rising edge.
  task automatic drive(input logic req, input logic wen, input logic gnt, input logic rv,
                       input logic en, input logic clr);
    @(posedge clk);
    #1;
    slv_if.req    = req;
    slv_if.wen    = wen;
    slv_if.add    = $urandom;
    slv_if.data   = $urandom;
    slv_if.be     = 4'($urandom);
    slv_if.user   = 2'($urandom);
    slv_if.lrdy   = 1'($urandom);
    mst_if.gnt    = gnt;
    mst_if.r_valid = rv;
    mst_if.r_data = $urandom;
    mst_if.r_opc  = 1'($urandom);
    mst_if.r_user = 2'($urandom);
    enable        = en;
    clear         = clr;
    #3;
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    enable = 1'b0;
    slv_if.req = 1'b0; slv_if.wen = 1'b0; slv_if.add = '0; slv_if.data = '0;
    slv_if.be = '0; slv_if.user = '0; slv_if.lrdy = 1'b0;
    mst_if.gnt = 1'b0; mst_if.r_valid = 1'b0; mst_if.r_data = '0;
    mst_if.r_opc = 1'b0; mst_if.r_user = '0;

    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state, no traffic
    drive(0, 1, 1, 0, 1, 0);
    lit("rst_outst", 64'(outstanding), 64'd0);
    lit("rst_idle", 64'(idle), 64'd1);
    lit("rst_full", 64'(full), 64'd0);
    lit("rst_err", 64'(err), 64'd0);

    // Six back-to-back reads, no responses
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 1, 0, 1, 0);
      lit("fill_outst", 64'(outstanding), 64'(k < 4 ? k : 4));
      lit("fill_mreq", 64'(mst_if.req), 64'(k < 4 ? 1 : 0));
      lit("fill_sgnt", 64'(slv_if.gnt), 64'(k < 4 ? 1 : 0));
    end
    lit("fill_full", 64'(full), 64'd1);

    // From full: r_valid with a pending read is still blocked this cycle
    drive(1, 1, 1, 1, 1, 0);
    lit("unblk_mreq0", 64'(mst_if.req), 64'd0);
    lit("unblk_sgnt0", 64'(slv_if.gnt), 64'd0);
    drive(1, 1, 1, 0, 1, 0);
    lit("unblk_outst3", 64'(outstanding), 64'd3);
    lit("unblk_mreq1", 64'(mst_if.req), 64'd1);
    drive(0, 1, 1, 0, 1, 0);
    lit("unblk_outst4", 64'(outstanding), 64'd4);

    // Down to 2, then simultaneous grant and response
    drive(0, 1, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 1, 0);
    lit("both_pre", 64'(outstanding), 64'd2);
    drive(0, 1, 1, 0, 1, 0);
    lit("both_post", 64'(outstanding), 64'd2);

    // Refill, then writes pass while full
    drive(1, 1, 1, 0, 1, 0);
    drive(1, 1, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 0, 1, 0);
      lit("wr_sgnt", 64'(slv_if.gnt), 64'd1);
      lit("wr_outst", 64'(outstanding), 64'd4);
    end
    drive(0, 1, 1, 0, 1, 0);
    lit("wr_post", 64'(outstanding), 64'd4);

    // Drain and underflow
    for (int k = 0; k < 4; k++) drive(0, 1, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 1, 0);
    lit("uf_pre_err", 64'(err), 64'd0);
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 1, 0, 1, 0);
      lit("uf_err", 64'(err), 64'd1);
      lit("uf_outst", 64'(outstanding), 64'd0);
    end
    drive(0, 1, 1, 0, 1, 1);
    drive(0, 1, 1, 0, 1, 0);
    lit("clr_err", 64'(err), 64'd0);

    // Disabled: transparent, counter frozen
    for (int k = 0; k < 4; k++) drive(1, 1, 1, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 1, 0, 0, 0);
      lit("dis_sgnt", 64'(slv_if.gnt), 64'd1);
      lit("dis_mreq", 64'(mst_if.req), 64'd1);
    end
    drive(0, 1, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    lit("dis_outst", 64'(outstanding), 64'd4);
    lit("dis_err", 64'(err), 64'd0);
    for (int k = 0; k < 4; k++) drive(0, 1, 1, 1, 1, 0);
    drive(0, 1, 1, 0, 1, 0);
    lit("dis_drain", 64'(outstanding), 64'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 59) == 0));
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    drive(0, 1, 1, 0, 1, 0);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
